// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared types and constants for the instruction encoder:
//               operation enum, MIPS opcode/funct codes, FSM state type and
//               the halt-word constant.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

  // Operation codes accepted on req_op; 27..31 are illegal
  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,  OP_SUBU = 5'd3,
    OP_AND   = 5'd4,  OP_OR   = 5'd5,  OP_XOR  = 5'd6,  OP_NOR  = 5'd7,
    OP_SLT   = 5'd8,  OP_SLL  = 5'd9,  OP_SRL  = 5'd10, OP_SRA  = 5'd11,
    OP_SLLV  = 5'd12, OP_SRLV = 5'd13, OP_SRAV = 5'd14, OP_JR   = 5'd15,
    OP_LW    = 5'd16, OP_SW   = 5'd17, OP_ADDI = 5'd18, OP_ADDIU = 5'd19,
    OP_ANDI  = 5'd20, OP_ORI  = 5'd21, OP_XORI = 5'd22, OP_BEQ  = 5'd23,
    OP_BNE   = 5'd24, OP_J    = 5'd25, OP_JAL  = 5'd26
  } enc_op_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

  // R-type funct field values
  localparam logic [5:0] c_FUNCT_ADD  = 6'h20;
  localparam logic [5:0] c_FUNCT_ADDU = 6'h21;
  localparam logic [5:0] c_FUNCT_SUB  = 6'h22;
  localparam logic [5:0] c_FUNCT_SUBU = 6'h23;
  localparam logic [5:0] c_FUNCT_AND  = 6'h24;
  localparam logic [5:0] c_FUNCT_OR   = 6'h25;
  localparam logic [5:0] c_FUNCT_XOR  = 6'h26;
  localparam logic [5:0] c_FUNCT_NOR  = 6'h27;
  localparam logic [5:0] c_FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] c_FUNCT_SLL  = 6'h00;
  localparam logic [5:0] c_FUNCT_SRL  = 6'h02;
  localparam logic [5:0] c_FUNCT_SRA  = 6'h03;
  localparam logic [5:0] c_FUNCT_SLLV = 6'h04;
  localparam logic [5:0] c_FUNCT_SRLV = 6'h06;
  localparam logic [5:0] c_FUNCT_SRAV = 6'h07;
  localparam logic [5:0] c_FUNCT_JR   = 6'h08;

  // I-type and J-type primary opcodes
  localparam logic [5:0] c_OPC_LW    = 6'h23;
  localparam logic [5:0] c_OPC_SW    = 6'h2B;
  localparam logic [5:0] c_OPC_ADDI  = 6'h08;
  localparam logic [5:0] c_OPC_ADDIU = 6'h09;
  localparam logic [5:0] c_OPC_ANDI  = 6'h0C;
  localparam logic [5:0] c_OPC_ORI   = 6'h0D;
  localparam logic [5:0] c_OPC_XORI  = 6'h0E;
  localparam logic [5:0] c_OPC_BEQ   = 6'h04;
  localparam logic [5:0] c_OPC_BNE   = 6'h05;
  localparam logic [5:0] c_OPC_J     = 6'h02;
  localparam logic [5:0] c_OPC_JAL   = 6'h03;

  // Terminator appended to the stream when the halt word is enabled
  localparam logic [31:0] c_HALT_WORD = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_if
// Description : Request, control and word-stream signals of the instruction
//               encoder. master = request source / word sink, slave = encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [4:0]  req_shamt;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        prog_end;
  logic        restart;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic [15:0] word_count;
  logic        illegal_op;
  logic        done;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm,
           req_target, prog_end, restart, out_ready,
    input  req_ready, out_valid, out_word, out_addr, word_count, illegal_op,
           done
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm,
           req_target, prog_end, restart, out_ready,
    output req_ready, out_valid, out_word, out_addr, word_count, illegal_op,
           done
  );
endinterface
`default_nettype wire

// File: rtl/enc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : enc_fifo
// Description : Show-ahead synchronous FIFO with flush; head entry is visible
//               on popData whenever empty is low. Push while full is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);
  localparam int          AW           = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;
  assign full     = (r_count == c_FULL_COUNT);
  assign empty    = (r_count == '0);
  assign popData  = r_mem[r_rdPtr];

  // Storage array; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= pushData;
  end

  // Pointer and occupancy bookkeeping; flush drops every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes MIPS-style requests into 32-bit words, buffers them
//               in enc_fifo and streams them with incrementing byte addresses.
//               Optional macro INSTR_ENC_HALT_WORD_EN appends 32'hFFFF_FFFF
//               as the final word when the program ends.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
  import enc_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);
  enc_state_t  r_state;
  logic        r_done;
  logic        r_illegal;
  logic [31:0] r_addr;
  logic [15:0] r_wordCount;
`ifdef INSTR_ENC_HALT_WORD_EN
  logic        r_haltPending;
`endif

  logic [31:0] w_encWord;
  logic        w_legal;
  logic        w_accept;
  logic        w_haltPush;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_pushData;
  logic [31:0] w_headWord;
  logic        w_full;
  logic        w_empty;

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] funct);
    return {6'h00, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // Translate the request fields into one instruction word
  always_comb begin
    w_encWord = '0;
    w_legal   = 1'b1;
    case (enc_op_t'(bus.req_op))
      OP_ADD:   w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_ADD);
      OP_ADDU:  w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_ADDU);
      OP_SUB:   w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_SUB);
      OP_SUBU:  w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_SUBU);
      OP_AND:   w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_AND);
      OP_OR:    w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_OR);
      OP_XOR:   w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_XOR);
      OP_NOR:   w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_NOR);
      OP_SLT:   w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_SLT);
      OP_SLL:   w_encWord = rType(5'd0, bus.req_rt, bus.req_rd, bus.req_shamt, c_FUNCT_SLL);
      OP_SRL:   w_encWord = rType(5'd0, bus.req_rt, bus.req_rd, bus.req_shamt, c_FUNCT_SRL);
      OP_SRA:   w_encWord = rType(5'd0, bus.req_rt, bus.req_rd, bus.req_shamt, c_FUNCT_SRA);
      OP_SLLV:  w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_SLLV);
      OP_SRLV:  w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_SRLV);
      OP_SRAV:  w_encWord = rType(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, c_FUNCT_SRAV);
      OP_JR:    w_encWord = {6'h00, bus.req_rs, 15'h0000, c_FUNCT_JR};
      OP_LW:    w_encWord = iType(c_OPC_LW,    bus.req_rs, bus.req_rt, bus.req_imm);
      OP_SW:    w_encWord = iType(c_OPC_SW,    bus.req_rs, bus.req_rt, bus.req_imm);
      OP_ADDI:  w_encWord = iType(c_OPC_ADDI,  bus.req_rs, bus.req_rt, bus.req_imm);
      OP_ADDIU: w_encWord = iType(c_OPC_ADDIU, bus.req_rs, bus.req_rt, bus.req_imm);
      OP_ANDI:  w_encWord = iType(c_OPC_ANDI,  bus.req_rs, bus.req_rt, bus.req_imm);
      OP_ORI:   w_encWord = iType(c_OPC_ORI,   bus.req_rs, bus.req_rt, bus.req_imm);
      OP_XORI:  w_encWord = iType(c_OPC_XORI,  bus.req_rs, bus.req_rt, bus.req_imm);
      OP_BEQ:   w_encWord = iType(c_OPC_BEQ,   bus.req_rs, bus.req_rt, bus.req_imm);
      OP_BNE:   w_encWord = iType(c_OPC_BNE,   bus.req_rs, bus.req_rt, bus.req_imm);
      OP_J:     w_encWord = {c_OPC_J,   bus.req_target};
      OP_JAL:   w_encWord = {c_OPC_JAL, bus.req_target};
      default:  w_legal   = 1'b0;
    endcase
  end

  // Requests are taken only while running with room; the full check keeps a
  // push from ever coinciding with a pop on a full buffer.
  assign bus.req_ready = (r_state == ST_RUN) && !w_full;
  assign w_accept      = bus.req_valid && bus.req_ready;

`ifdef INSTR_ENC_HALT_WORD_EN
  assign w_haltPush = (r_state == ST_HALT) && r_haltPending && !w_full;
  assign w_pushData = w_haltPush ? c_HALT_WORD : w_encWord;
`else
  assign w_haltPush = 1'b0;
  assign w_pushData = w_encWord;
`endif

  // Restart flushes the buffer, so nothing moves through it on that cycle
  assign w_push = !bus.restart && ((w_accept && w_legal) || w_haltPush);
  assign w_pop  = !bus.restart && !w_empty && bus.out_ready;

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.restart),
    .push     (w_push),
    .pushData (w_pushData),
    .pop      (w_pop),
    .popData  (w_headWord),
    .full     (w_full),
    .empty    (w_empty)
  );

  // Head word is held by the FIFO until popped, so it stays stable under stall
  assign bus.out_valid  = !w_empty;
  assign bus.out_word   = w_empty ? 32'h0000_0000 : w_headWord;
  assign bus.out_addr   = r_addr;
  assign bus.word_count = r_wordCount;
  assign bus.illegal_op = r_illegal;
  assign bus.done       = r_done;

  // Control FSM with address, word counter and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
      r_addr        <= BASE_ADDR;
      r_wordCount   <= 16'h0000;
`ifdef INSTR_ENC_HALT_WORD_EN
      r_haltPending <= 1'b0;
`endif
    end else if (bus.restart) begin
      r_state       <= ST_RUN;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
      r_addr        <= BASE_ADDR;
      r_wordCount   <= 16'h0000;
`ifdef INSTR_ENC_HALT_WORD_EN
      r_haltPending <= 1'b0;
`endif
    end else begin
      if (w_accept && !w_legal) r_illegal <= 1'b1;
      if (w_pop) begin
        r_addr <= r_addr + 32'd4;
        if (r_wordCount != 16'hFFFF) r_wordCount <= r_wordCount + 16'd1;
      end
      case (r_state)
        ST_RUN: begin
          // A request accepted alongside prog_end is already being enqueued
          if (bus.prog_end) begin
            r_state       <= ST_HALT;
`ifdef INSTR_ENC_HALT_WORD_EN
            r_haltPending <= 1'b1;
`endif
          end
        end
        ST_HALT: begin
`ifdef INSTR_ENC_HALT_WORD_EN
          if (r_haltPending) begin
            if (!w_full) r_haltPending <= 1'b0;
          end else if (w_empty) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
`else
          if (w_empty) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
`endif
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_RUN;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire
